button_encoder: RTL and testbench



---
 rtl/button_encoder_pkg.sv | 28 ++
 rtl/button_encoder_sync_2ff.sv | 26 ++
 rtl/button_encoder.sv | 129 ++++++++++++
 tb/tb_button_encoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/button_encoder_pkg.sv
// Shared constants, FSM state encoding and one-hot helpers for button_encoder.
package button_encoder_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

  typedef enum logic [2:0] {
    BTN_IDLE_S      = 3'd0,
    BTN_DEB_PRESS_S = 3'd1,
    BTN_PRESSED_S   = 3'd2,
    BTN_DEB_REL_S   = 3'd3,
    BTN_LOCKOUT_S   = 3'd4
  } btn_state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for one-hot input; callers check is_onehot4 first.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_encoder_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; Q resets to zero.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= D;
      sync_q <= meta_q;
    end
  end

  assign Q = sync_q;

endmodule

// File: rtl/button_encoder.sv
// Debounces four colour buttons and encodes a single held button into KEY/KEY_VALID.
// Optional BTN_PRESS_PULSE_EN adds a one-cycle KEY_PRESS strobe on each accepted press.
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  output logic [1:0] KEY,
  output logic       KEY_VALID,
`ifdef BTN_PRESS_PULSE_EN
  output logic       KEY_PRESS,
`endif
  output btn_state_e STATE_DBG
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s;
  btn_state_e       state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       key_q;
  logic             kv_q;
`ifdef BTN_PRESS_PULSE_EN
  logic             press_q;
`endif

  sync_2ff #(.WIDTH(4)) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (BTN),
    .Q     (s)
  );

  // KEY/KEY_VALID is a level-valid pair with no ready: KEY is stable whenever
  // KEY_VALID is high and only changes on the edge where KEY_VALID rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= BTN_IDLE_S;
      cand_q  <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      kv_q    <= 1'b0;
`ifdef BTN_PRESS_PULSE_EN
      press_q <= 1'b0;
`endif
    end else begin
`ifdef BTN_PRESS_PULSE_EN
      press_q <= 1'b0;
`endif
      case (state_q)
        BTN_IDLE_S: begin
          if (s != 4'd0) begin
            cand_q  <= s;
            cnt_q   <= CNT_ONE;
            state_q <= BTN_DEB_PRESS_S;
          end
        end
        BTN_DEB_PRESS_S: begin
          if (s == 4'd0) begin
            state_q <= BTN_IDLE_S;
          end else if (s != cand_q) begin
            cand_q <= s;
            cnt_q  <= CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
            if (is_onehot4(s)) begin
              key_q   <= enc4(s);
              kv_q    <= 1'b1;
              state_q <= BTN_PRESSED_S;
`ifdef BTN_PRESS_PULSE_EN
              press_q <= 1'b1;
`endif
            end else begin
              cnt_q   <= '0;
              state_q <= BTN_LOCKOUT_S;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        BTN_PRESSED_S: begin
          if (!s[key_q]) begin
            cnt_q   <= CNT_ONE;
            state_q <= BTN_DEB_REL_S;
          end
        end
        BTN_DEB_REL_S: begin
          if (s[key_q]) begin
            state_q <= BTN_PRESSED_S;
          end else if (cnt_q == CNT_LAST) begin
            kv_q <= 1'b0;
            if (s == 4'd0) begin
              state_q <= BTN_IDLE_S;
            end else begin
              cnt_q   <= '0;
              state_q <= BTN_LOCKOUT_S;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        BTN_LOCKOUT_S: begin
          // cnt_q counts consecutive all-released samples seen so far.
          if (s != 4'd0) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= BTN_IDLE_S;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= BTN_IDLE_S;
      endcase
    end
  end

  assign KEY       = key_q;
  assign KEY_VALID = kv_q;
  assign STATE_DBG = state_q;
`ifdef BTN_PRESS_PULSE_EN
  assign KEY_PRESS = press_q;
`endif

endmodule

// File: tb/tb_button_encoder.sv
// Bench for button_encoder with DEBOUNCE_CYCLES=4: vector table, edge scoreboard, corner sequences.
module tb_button_encoder;
  import button_encoder_pkg::*;

  localparam int D   = 4;
  localparam int LAT = D + 2;
  localparam int W   = 35;

  logic       CLK;
  logic       RST_N;
  logic [3:0] BTN;
  logic [1:0] KEY;
  logic       KEY_VALID;
  btn_state_e STATE_DBG;
`ifdef BTN_PRESS_PULSE_EN
  logic       KEY_PRESS;
  int         press_cnt;
`endif

  button_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BTN       (BTN),
    .KEY       (KEY),
    .KEY_VALID (KEY_VALID),
`ifdef BTN_PRESS_PULSE_EN
    .KEY_PRESS (KEY_PRESS),
`endif
    .STATE_DBG (STATE_DBG)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total;
  int bad;
  int cyc;
  int rises;
  logic kv_prev;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [3:0] btn;
    int         hold;
    int         ev;      // 0 none, 1 rise, 2 fall, LAT edges after drive
    logic [1:0] ev_key;
    logic       kv;
    logic [1:0] key;
    btn_state_e st;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int at, input logic kv, input logic [1:0] key);
    exp_q.push_back({32'(at), kv, key});
    if (kv) rises++;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge CLK);
    BTN = v.btn;
    if (v.ev == 1) push_ev(cyc + LAT, 1'b1, v.ev_key);
    if (v.ev == 2) push_ev(cyc + LAT, 1'b0, v.ev_key);
    repeat (v.hold) @(posedge CLK);
    #2;
    chk($sformatf("vec%0d_kv", idx), 64'(KEY_VALID), 64'(v.kv));
    chk($sformatf("vec%0d_key", idx), 64'(KEY), 64'(v.key));
    chk($sformatf("vec%0d_state", idx), 64'(STATE_DBG), 64'(v.st));
  endtask

  // scoreboard: every KEY_VALID edge must match the next queued expectation
  always @(posedge CLK) begin
    logic [W-1:0] e;
    logic         rose;
    cyc++;
    #1;
    rose = KEY_VALID && !kv_prev;
    if (KEY_VALID !== kv_prev) begin
      if (exp_q.size() == 0) begin
        chk("kv_unexpected_edge", 64'(KEY_VALID), 64'(kv_prev));
      end else begin
        e = exp_q.pop_front();
        chk("kv_edge", 64'({32'(cyc), KEY_VALID, KEY}), 64'(e));
      end
      kv_prev = KEY_VALID;
    end
`ifdef BTN_PRESS_PULSE_EN
    if (KEY_PRESS === 1'b1) press_cnt++;
    if (KEY_PRESS === 1'b1 || rose) chk("key_press_pulse", 64'(KEY_PRESS), 64'(rose));
`else
    if (rose) e = '0;
`endif
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int r;
    total = 0; bad = 0; cyc = 0; rises = 0; kv_prev = 1'b0;
`ifdef BTN_PRESS_PULSE_EN
    press_cnt = 0;
`endif
    RST_N = 1'b0;
    BTN   = 4'd0;

    tbl[0]  = '{4'b0100, 20, 1, 2'd2, 1'b1, 2'd2, BTN_PRESSED_S};
    tbl[1]  = '{4'b0000, 10, 2, 2'd2, 1'b0, 2'd2, BTN_IDLE_S};
    tbl[2]  = '{4'b1001, 12, 0, 2'd0, 1'b0, 2'd0, BTN_LOCKOUT_S};
    tbl[3]  = '{4'b0000,  6, 0, 2'd0, 1'b0, 2'd0, BTN_IDLE_S};
    tbl[4]  = '{4'b0010, 10, 1, 2'd1, 1'b1, 2'd1, BTN_PRESSED_S};
    tbl[5]  = '{4'b0000, 10, 2, 2'd1, 1'b0, 2'd1, BTN_IDLE_S};
    tbl[6]  = '{4'b1000, 10, 1, 2'd3, 1'b1, 2'd3, BTN_PRESSED_S};
    tbl[7]  = '{4'b0000,  2, 0, 2'd3, 1'b1, 2'd3, BTN_PRESSED_S};
    tbl[8]  = '{4'b1000, 10, 0, 2'd3, 1'b1, 2'd3, BTN_PRESSED_S};
    tbl[9]  = '{4'b0000, 10, 2, 2'd3, 1'b0, 2'd3, BTN_IDLE_S};
    tbl[10] = '{4'b0010, 10, 1, 2'd1, 1'b1, 2'd1, BTN_PRESSED_S};
    tbl[11] = '{4'b0011,  5, 0, 2'd1, 1'b1, 2'd1, BTN_PRESSED_S};
    tbl[12] = '{4'b0001, 10, 2, 2'd1, 1'b0, 2'd1, BTN_LOCKOUT_S};
    tbl[13] = '{4'b0000, 10, 0, 2'd1, 1'b0, 2'd1, BTN_IDLE_S};

    #3;
    chk("rst_kv", 64'(KEY_VALID), 64'd0);
    chk("rst_key", 64'(KEY), 64'd0);
    chk("rst_state", 64'(STATE_DBG), 64'(BTN_IDLE_S));
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);

    for (int i = 0; i < 2; i++) run_vec(tbl[i], i);

    // bounce: alternate press/release every cycle, then hold colour 0
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      BTN = (i % 2 == 0) ? 4'b0001 : 4'b0000;
    end
    @(negedge CLK);
    BTN = 4'b0001;
    push_ev(cyc + LAT, 1'b1, 2'd0);
    repeat (10) @(posedge CLK);
    #2;
    chk("bounce_kv", 64'(KEY_VALID), 64'd1);
    chk("bounce_key", 64'(KEY), 64'd0);
    @(negedge CLK);
    BTN = 4'b0000;
    push_ev(cyc + LAT, 1'b0, 2'd0);
    repeat (10) @(posedge CLK);

    for (int i = 2; i < 14; i++) run_vec(tbl[i], i);

    // reset while a press is accepted, button kept held through reset
    @(negedge CLK);
    BTN = 4'b0100;
    push_ev(cyc + LAT, 1'b1, 2'd2);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("pre_rst_kv", 64'(KEY_VALID), 64'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_kv", 64'(KEY_VALID), 64'd0);
    chk("async_rst_key", 64'(KEY), 64'd0);
    chk("async_rst_state", 64'(STATE_DBG), 64'(BTN_IDLE_S));
    kv_prev = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    r = cyc;
    push_ev(r + LAT, 1'b1, 2'd2);
    repeat (10) @(posedge CLK);
    #2;
    chk("post_rst_kv", 64'(KEY_VALID), 64'd1);
    chk("post_rst_key", 64'(KEY), 64'd2);
    @(negedge CLK);
    BTN = 4'b0000;
    push_ev(cyc + LAT, 1'b0, 2'd2);
    repeat (10) @(posedge CLK);
    #2;
    chk("final_kv", 64'(KEY_VALID), 64'd0);
    chk("final_key_held", 64'(KEY), 64'd2);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
`ifdef BTN_PRESS_PULSE_EN
    chk("press_count", 64'(press_cnt), 64'(rises));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
